// File: rtl/req_dispatch_if.sv
// Upstream and downstream request/acknowledge bundle for the one-to-N dispatcher.
// slave is the dispatcher's view; master is the view of whatever drives it.
interface req_dispatch_if #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 3
);
  logic            mode_i;
  logic            req_i;
  logic [DW-1:0]   data_i;
  logic [AW-1:0]   dest_i;
  logic            ack_i;
  logic [N-1:0]    req_o;
  logic [N*DW-1:0] data_o;
  logic [N-1:0]    ack_o;

  modport slave (
    input  mode_i, req_i, data_i, dest_i, ack_o,
    output ack_i, req_o, data_o
  );

  modport master (
    output mode_i, req_i, data_i, dest_i, ack_o,
    input  ack_i, req_o, data_o
  );
endinterface

// File: rtl/req_dispatch.sv
// One-to-N request dispatcher: steers each upstream word into a one-entry slot
// per downstream channel, chosen by explicit destination or round-robin scan.
module req_dispatch #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  req_dispatch_if.slave bus,
  output logic          busy,
  output logic [7:0]    drop_cnt
);
  logic [N-1:0]    req_q, req_d, free;
  logic [N*DW-1:0] data_q, data_d;
  logic [AW-1:0]   ptr_q, ptr_d, tgt;
  logic [7:0]      drop_q, drop_d;
  logic            hit, dest_ok, fill, drop;
  int              idx;

  // A slot accepts a new word if empty or if it drains on this same edge.
  assign free    = ~req_q | bus.ack_o;
  assign dest_ok = int'(bus.dest_i) < N;

  always_comb begin
    hit = 1'b0;
    tgt = '0;
    idx = 0;
    if (bus.mode_i) begin
      for (int i = 0; i < N; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= N) idx = idx - N;
        if (!hit && free[idx]) begin
          hit = 1'b1;
          tgt = idx[AW-1:0];
        end
      end
    end else if (dest_ok) begin
      tgt = bus.dest_i;
      hit = free[bus.dest_i];
    end
  end

  // Invalid routed destinations are acknowledged and discarded.
  assign drop       = bus.req_i & ~bus.mode_i & ~dest_ok;
  assign fill       = bus.req_i & hit;
  assign bus.ack_i  = fill | drop;

  always_comb begin
    ptr_d = ptr_q;
    if (fill && bus.mode_i)
      ptr_d = (int'(tgt) == N - 1) ? '0 : tgt + 1'b1;
  end

  assign drop_d = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_slot
    logic load;
    assign load = fill && (tgt == AW'(gi));
    assign req_d[gi] = load | (req_q[gi] & ~bus.ack_o[gi]);
    assign data_d[gi*DW +: DW] = load ? bus.data_i : data_q[gi*DW +: DW];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q  <= '0;
      data_q <= '0;
      ptr_q  <= '0;
      drop_q <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
      ptr_q  <= ptr_d;
      drop_q <= drop_d;
    end
  end

  assign bus.req_o  = req_q;
  assign bus.data_o = data_q;
  assign busy       = |req_q;
  assign drop_cnt   = drop_q;
endmodule

// File: tb/tb_req_dispatch.sv
// Bench for req_dispatch: directed scenarios plus random traffic against a
// slot/pointer reference model; an N=6 instance covers invalid destinations.
module tb_req_dispatch;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  req_dispatch_if #(.N(8), .DW(8), .AW(3)) b8 ();
  req_dispatch_if #(.N(6), .DW(8), .AW(3)) b6 ();
  logic       busy8, busy6;
  logic [7:0] drop8, drop6;

  req_dispatch #(.N(8), .DW(8), .AW(3)) dut8 (
    .clk(clk), .rstn(rstn), .bus(b8.slave), .busy(busy8), .drop_cnt(drop8));
  req_dispatch #(.N(6), .DW(8), .AW(3)) dut6 (
    .clk(clk), .rstn(rstn), .bus(b6.slave), .busy(busy6), .drop_cnt(drop6));

  int checks = 0;
  int errors = 0;

  // Reference model of the 8-channel instance
  bit         m_v[N];
  logic [7:0] m_d[N];
  int         m_ptr;

  function automatic logic [7:0] lane(int k);
    return b8.data_o[k*8 +: 8];
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    for (int k = 0; k < N; k++) m[k] = m_v[k];
    return m;
  endfunction

  // Target slot for the current inputs, or -1 when nothing can accept.
  function automatic int pick();
    if (!b8.mode_i)
      return (!m_v[b8.dest_i] || b8.ack_o[b8.dest_i]) ? int'(b8.dest_i) : -1;
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (!m_v[k] || b8.ack_o[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = 8'h00;
    end
    m_ptr = 0;
  endtask

  // One rising edge; the model consumes the same inputs the DUT saw.
  task automatic tick();
    int t = pick();
    bit rq = b8.req_i;
    bit md = b8.mode_i;
    logic [7:0] dv = b8.data_i;
    logic [7:0] ak = b8.ack_o;
    @(posedge clk);
    for (int k = 0; k < N; k++)
      if (m_v[k] && ak[k]) m_v[k] = 1'b0;
    if (rq && t >= 0) begin
      m_v[t] = 1'b1;
      m_d[t] = dv;
      if (md) m_ptr = (t + 1) % N;
    end
    #1;
  endtask

  task automatic drive8(bit md, bit rq, logic [7:0] dv, logic [2:0] ds, logic [7:0] ak);
    b8.mode_i = md;
    b8.req_i  = rq;
    b8.data_i = dv;
    b8.dest_i = ds;
    b8.ack_o  = ak;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++;
    if (b8.req_o !== 8'h00 || b8.data_o !== 64'h0 || busy8 !== 1'b0 || drop8 !== 8'h00) begin
      errors++;
      $display("FAIL reset8 req_o %h data_o %h busy %b drop %h, expected all zero",
               b8.req_o, b8.data_o, busy8, drop8);
    end
    checks++;
    if (b6.req_o !== 6'h00 || drop6 !== 8'h00) begin
      errors++;
      $display("FAIL reset6 req_o %h drop %h, expected zero", b6.req_o, drop6);
    end
    @(negedge clk);
    rstn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_routed_fill();
    logic [7:0] dv[3] = '{8'h11, 8'h22, 8'h33};
    logic [2:0] ds[3] = '{3'd2, 3'd5, 3'd7};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive8(1'b0, 1'b1, dv[i], ds[i], 8'h00);
      #1;
      checks++;
      if (b8.ack_i !== 1'b1) begin
        errors++;
        $display("FAIL routed_ack word %0d got %b expected 1", i, b8.ack_i);
      end
      tick();
    end
    @(negedge clk);
    b8.req_i = 1'b0;
    #1;
    checks++;
    if (b8.req_o !== 8'b1010_0100 || lane(2) !== 8'h11 || lane(5) !== 8'h22 ||
        lane(7) !== 8'h33 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL routed_fill req_o %b lanes %h/%h/%h busy %b, expected 10100100 11/22/33 1",
               b8.req_o, lane(2), lane(5), lane(7), busy8);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive8(1'b0, 1'b1, 8'h55, 3'd5, 8'h00);
      #1;
      checks++;
      if (b8.ack_i !== 1'b0) begin
        errors++;
        $display("FAIL routed_stall cycle %0d ack_i %b expected 0", c, b8.ack_i);
      end
      tick();
    end
    @(negedge clk);
    b8.ack_o = 8'h20;
    #1;
    checks++;
    if (b8.ack_i !== 1'b1) begin
      errors++;
      $display("FAIL routed_release ack_i %b expected 1", b8.ack_i);
    end
    tick();
    checks++;
    if (b8.req_o !== 8'b1010_0100 || lane(5) !== 8'h55) begin
      errors++;
      $display("FAIL routed_refill req_o %b lane5 %h, expected 10100100 55", b8.req_o, lane(5));
    end
    $display("test_routed_fill done");
  endtask

  task automatic test_drain_refill();
    int seen = 0;
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'h3C, 3'd3, 8'h00);
    tick();
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'h44, 3'd3, 8'h08);
    #1;
    checks++;
    if (b8.ack_i !== 1'b1 || lane(3) !== 8'h3C) begin
      errors++;
      $display("FAIL drain_refill_ack ack_i %b lane3 %h, expected 1 3c", b8.ack_i, lane(3));
    end
    if (b8.req_o[3] && b8.ack_o[3]) seen++;
    tick();
    checks++;
    if (b8.req_o[3] !== 1'b1 || lane(3) !== 8'h44) begin
      errors++;
      $display("FAIL drain_refill_data req3 %b lane3 %h, expected 1 44", b8.req_o[3], lane(3));
    end
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    tick();
    checks++;
    if (b8.req_o[3] !== 1'b1 || lane(3) !== 8'h44) begin
      errors++;
      $display("FAIL drain_refill_hold req3 %b lane3 %h, expected 1 44", b8.req_o[3], lane(3));
    end
    @(negedge clk);
    b8.ack_o = 8'h08;
    #1;
    if (b8.req_o[3] && b8.ack_o[3]) seen++;
    tick();
    checks++;
    if (b8.req_o[3] !== 1'b0 || lane(3) !== 8'h44 || seen != 2) begin
      errors++;
      $display("FAIL drain_refill_consume req3 %b lane3 %h transfers %0d, expected 0 44 2",
               b8.req_o[3], lane(3), seen);
    end
    @(negedge clk);
    b8.ack_o = 8'hFF;
    tick();
    checks++;
    if (b8.req_o !== 8'h00 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL drain_all req_o %b busy %b, expected 0 0", b8.req_o, busy8);
    end
    $display("test_drain_refill done");
  endtask

  task automatic test_rr_wrap();
    logic [8:0] m;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive8(1'b1, 1'b1, 8'(i), 3'd0, 8'h00);
      #1;
      checks++;
      if (b8.ack_i !== 1'b1) begin
        errors++;
        $display("FAIL rr_ack word %0d ack_i %b expected 1", i, b8.ack_i);
      end
      tick();
      m = (9'd1 << (i + 1)) - 9'd1;
      checks++;
      if (b8.req_o !== m[7:0] || lane(i) !== 8'(i)) begin
        errors++;
        $display("FAIL rr_slot word %0d req_o %b lane %h, expected %b %h",
                 i, b8.req_o, lane(i), m[7:0], 8'(i));
      end
    end
    @(negedge clk);
    drive8(1'b1, 1'b1, 8'h08, 3'd0, 8'h00);
    #1;
    checks++;
    if (b8.ack_i !== 1'b0) begin
      errors++;
      $display("FAIL rr_full ack_i %b expected 0", b8.ack_i);
    end
    tick();
    @(negedge clk);
    b8.ack_o = 8'h10;
    #1;
    checks++;
    if (b8.ack_i !== 1'b1) begin
      errors++;
      $display("FAIL rr_release ack_i %b expected 1", b8.ack_i);
    end
    tick();
    checks++;
    if (b8.req_o !== 8'hFF || lane(4) !== 8'h08) begin
      errors++;
      $display("FAIL rr_ninth req_o %b lane4 %h, expected ff 08", b8.req_o, lane(4));
    end
    // Slots 4 and 6 both free: a pointer at 5 must pick slot 6.
    @(negedge clk);
    drive8(1'b1, 1'b1, 8'h09, 3'd0, 8'h50);
    tick();
    checks++;
    if (b8.req_o !== 8'b1110_1111 || lane(6) !== 8'h09 || lane(4) !== 8'h08) begin
      errors++;
      $display("FAIL rr_ptr5 req_o %b lane6 %h lane4 %h, expected 11101111 09 08",
               b8.req_o, lane(6), lane(4));
    end
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF);
    tick();
    $display("test_rr_wrap done");
  endtask

  task automatic test_rr_skip();
    do_reset();
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'hA6, 3'd6, 8'h00);
    tick();
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'hA7, 3'd7, 8'h00);
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive8(1'b1, 1'b1, 8'hB0 + 8'(i), 3'd0, 8'h00);
      tick();
    end
    @(negedge clk);
    drive8(1'b1, 1'b0, 8'h00, 3'd0, 8'h01);
    tick();
    checks++;
    if (b8.req_o !== 8'b1111_1110 || lane(5) !== 8'hB5 || lane(7) !== 8'hA7) begin
      errors++;
      $display("FAIL rr_skip_setup req_o %b lane5 %h lane7 %h, expected 11111110 b5 a7",
               b8.req_o, lane(5), lane(7));
    end
    @(negedge clk);
    drive8(1'b1, 1'b1, 8'hC0, 3'd0, 8'h00);
    #1;
    checks++;
    if (b8.ack_i !== 1'b1) begin
      errors++;
      $display("FAIL rr_skip_ack ack_i %b expected 1", b8.ack_i);
    end
    tick();
    checks++;
    if (b8.req_o !== 8'hFF || lane(0) !== 8'hC0) begin
      errors++;
      $display("FAIL rr_skip_slot0 req_o %b lane0 %h, expected ff c0", b8.req_o, lane(0));
    end
    // Slots 1 and 2 free: a pointer at 1 must pick slot 1.
    @(negedge clk);
    drive8(1'b1, 1'b1, 8'hC1, 3'd0, 8'h06);
    tick();
    checks++;
    if (b8.req_o !== 8'b1111_1011 || lane(1) !== 8'hC1) begin
      errors++;
      $display("FAIL rr_skip_ptr1 req_o %b lane1 %h, expected 11111011 c1", b8.req_o, lane(1));
    end
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'hFF);
    tick();
    $display("test_rr_skip done");
  endtask

  task automatic test_drop();
    int exp_drop;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      b6.mode_i = 1'b0;
      b6.req_i  = 1'b1;
      b6.dest_i = (i % 2 == 0) ? 3'd6 : 3'd7;
      b6.data_i = 8'($urandom_range(0, 255));
      b6.ack_o  = 6'($urandom_range(0, 63));
      #1;
      checks++;
      if (b6.ack_i !== 1'b1) begin
        errors++;
        $display("FAIL drop_ack word %0d ack_i %b expected 1", i, b6.ack_i);
      end
      tick();
      exp_drop = (i + 1 > 255) ? 255 : i + 1;
      checks++;
      if (b6.req_o !== 6'h00 || drop6 !== 8'(exp_drop)) begin
        errors++;
        $display("FAIL drop_cnt word %0d req_o %b drop %0d, expected 000000 %0d",
                 i, b6.req_o, drop6, exp_drop);
      end
    end
    @(negedge clk);
    b6.req_i = 1'b0;
    b6.ack_o = 6'h00;
    $display("test_drop done drop_cnt %0d", drop6);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'h5A, 3'd1, 8'h00);
    tick();
    @(negedge clk);
    drive8(1'b0, 1'b1, 8'hA5, 3'd3, 8'h00);
    tick();
    @(negedge clk);
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    #2;
    checks++;
    if (b8.req_o !== 8'b0000_1010 || busy8 !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup req_o %b busy %b, expected 00001010 1", b8.req_o, busy8);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (b8.req_o !== 8'h00 || b8.data_o !== 64'h0 || busy8 !== 1'b0 ||
        drop8 !== 8'h00 || drop6 !== 8'h00) begin
      errors++;
      $display("FAIL areset req_o %b data_o %h busy %b drop8 %0d drop6 %0d, expected all zero",
               b8.req_o, b8.data_o, busy8, drop8, drop6);
    end
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int t;
    bit exp_ack;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      drive8(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
             8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
      #1;
      t = pick();
      exp_ack = b8.req_i && (t >= 0);
      checks++;
      if (b8.ack_i !== exp_ack) begin
        errors++;
        $display("FAIL rand_ack cycle %0d ack_i %b expected %b", c, b8.ack_i, exp_ack);
      end
      tick();
      checks++;
      if (b8.req_o !== m_mask() || busy8 !== (|m_mask())) begin
        errors++;
        $display("FAIL rand_req cycle %0d req_o %b busy %b, expected %b %b",
                 c, b8.req_o, busy8, m_mask(), |m_mask());
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (lane(k) !== m_d[k]) begin
          errors++;
          $display("FAIL rand_data cycle %0d lane %0d got %h expected %h", c, k, lane(k), m_d[k]);
        end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    drive8(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    b6.mode_i = 1'b0;
    b6.req_i  = 1'b0;
    b6.data_i = 8'h00;
    b6.dest_i = 3'd0;
    b6.ack_o  = 6'h00;
    model_clear();
    test_reset();
    test_routed_fill();
    test_drain_refill();
    test_rr_wrap();
    test_rr_skip();
    test_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/req_dispatch.md
# req_dispatch

One-to-N request dispatcher, the fan-out counterpart of the N-to-one arbiters. It accepts a single upstream request/acknowledge stream carrying a data word and steers each word to one of N downstream request/acknowledge channels. The target is either the explicit destination index or the next free channel in round-robin order. Each downstream channel has a one-entry holding slot, so one stalled consumer does not block transfers to the others unless that consumer is the selected target.

## Interface
- N, 8: number of downstream channels, 2..2**AW
- DW, 8: data word width
- AW, 3: destination index width; N <= 2**AW
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- mode_i  input  1  0 = routed (use dest_i), 1 = round-robin (ignore dest_i)
- req_i  input  1  upstream request; held with data_i/dest_i until acknowledged
- data_i  input  DW  upstream data
- dest_i  input  AW  destination channel index (routed mode)
- ack_i  output  1  upstream acknowledge, combinational
- req_o  output  N  per-channel request, registered (slot valid)
- data_o  output  N*DW  per-channel data; channel k at [k*DW +: DW], registered
- ack_o  input  N  per-channel acknowledge from consumers
- busy  output  1  OR of all slot-valid bits
- drop_cnt  output  8  saturating count of words dropped for invalid destination

## Operation
- Transfer rule, both sides: a word moves on the rising clk edge where req and ack are both 1.
- Slot k is "free" when req_o[k]=0, or when req_o[k]=1 and ack_o[k]=1 in the same cycle (it drains while it refills).
- Routed mode, dest_i < N: target = dest_i. ack_i = req_i & free(dest_i).
- Routed mode, dest_i >= N: ack_i = req_i. The word is discarded with no slot change, and drop_cnt increments, saturating at 255.
- Round-robin mode: target = first free slot scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. ack_i = req_i & (any free slot).
- Round-robin pointer update: on an upstream transfer, ptr <= (target+1) mod N. ptr does not change in routed mode.
- On an upstream transfer to slot k: req_o[k] <= 1 and data_o[k] <= data_i.
- On a downstream transfer on k with no refill: req_o[k] <= 0, and data_o[k] holds its last value.
- Simultaneous drain and refill of slot k: req_o[k] stays 1 and data_o[k] takes the new word.
- ack_i = 0 whenever req_i = 0.
- At most one slot is filled per cycle. Any number of slots may drain in the same cycle.
- mode_i is sampled every cycle and may change between words. ptr and slot contents are retained across mode changes.
- ack_o[k] while req_o[k]=0 is ignored.

## Timing
- Reset (asynchronous, immediate): req_o=0, data_o=0, ptr=0, drop_cnt=0, busy=0. ack_i then follows req_i per the rules above, so ack_i=1 is possible one cycle after reset is released.
- Reset mid-operation: all held words are lost. No partial transfer completes on the reset edge.
- Latency: a word accepted at edge t is presented on req_o[k] from edge t to t+1. Minimum upstream-to-downstream latency is 1 cycle.
- Throughput: 1 word/cycle upstream, sustained while target slots drain every cycle.
- Combinational paths: req_i, dest_i, mode_i, ack_o → ack_i. There is no combinational path from upstream to req_o or data_o.
- busy is derived combinationally from the registered req_o.

## Test plan
- Reset and routed fill: after reset, routed mode, send data 0x11, 0x22, 0x33 to dest 2, 5, 7 with ack_o=0. Required: each ack_i=1, req_o=8'b1010_0100, data_o lanes 2/5/7 = 0x11/0x22/0x33, busy=1. Then a 4th word to dest 5 → ack_i=0 until ack_o[5] pulses.
- Drain plus refill: slot 3 full and a new word 0x44 to dest 3 with ack_o[3]=1 in the same cycle. Required: ack_i=1, req_o[3] stays 1, data lane 3 = 0x44 next cycle, and the old word is counted as consumed once.
- Invalid destination: N=6, AW=3, send dest 6 and dest 7 (300 words total). Required: ack_i=1 for each, req_o unchanged, drop_cnt saturates at 255.
- Round-robin wrap: mode 1, all ack_o=0, send 8 words 0x00..0x07. Required: they land in slots 0..7 in order and ptr=0 afterward. A 9th word gets ack_i=0. Release ack_o[4] only → the 9th word goes to slot 4, then ptr=5.
- Round-robin skip: ptr=6, slots 6 and 7 full, slot 0 free. Required: next word goes to slot 0, then ptr=1.
- Async reset mid-stream: assert rstn=0 between edges while slots 1 and 3 are full. Required: req_o=0, data_o=0 and busy=0 immediately, without waiting for a clock edge, and drop_cnt=0.
